// File: rtl/scan_pkg.sv
// Shared types and default widths for the dmem range max scanner.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } scan_state_t;

  localparam int SCAN_AW = 32;
  localparam int SCAN_DW = 32;
  localparam int SCAN_CW = 16;

endpackage

// File: rtl/max_accum.sv
// Registered compare-and-hold: keeps the running unsigned maximum of valid words.
// SCAN_MAX_ADDR_EN adds the address of the first occurrence of that maximum.
module max_accum
  import scan_pkg::*;
#(
  parameter int DW = SCAN_DW
`ifdef SCAN_MAX_ADDR_EN
  ,
  parameter int AW = SCAN_AW
`endif
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
`ifdef SCAN_MAX_ADDR_EN
  input  logic [AW-1:0] addr_i,
  output logic [AW-1:0] max_addr_o,
`endif
  output logic [DW-1:0] max_val_o
);

  logic [DW-1:0] max_val_q, max_val_d;
  logic          take;

  // Strictly greater only, so a tie leaves the earlier word in place.
  always_comb begin
    take      = valid_i && (data_i > max_val_q);
    max_val_d = max_val_q;
    if (clear_i) begin
      max_val_d = '0;
    end else if (take) begin
      max_val_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      max_val_q <= '0;
    end else begin
      max_val_q <= max_val_d;
    end
  end

  assign max_val_o = max_val_q;

`ifdef SCAN_MAX_ADDR_EN
  logic [AW-1:0] max_addr_q, max_addr_d;

  // On clear the caller presents the range base on addr_i.
  always_comb begin
    max_addr_d = max_addr_q;
    if (clear_i || take) begin
      max_addr_d = addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      max_addr_q <= '0;
    end else begin
      max_addr_q <= max_addr_d;
    end
  end

  assign max_addr_o = max_addr_q;
`endif

endmodule

// File: rtl/dmem_max_scanner.sv
// Walks a word range through dmem's read port, one read per cycle, and reports the unsigned maximum.
// Define SCAN_MAX_ADDR_EN to also report the address of the first occurrence of the maximum.
module dmem_max_scanner
  import scan_pkg::*;
#(
  parameter int AW = SCAN_AW,
  parameter int DW = SCAN_DW,
  parameter int CW = SCAN_CW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [CW-1:0] count_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] max_val_o,
`ifdef SCAN_MAX_ADDR_EN
  output logic [AW-1:0] max_addr_o,
`endif
  output logic          mem_rd_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_din_i
);

  scan_state_t   state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          inflight_q;
  logic          accept;

  // Issue side: the remaining-read counter decides when the last address goes out.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    remain_d   = remain_q;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept = 1'b1;
          busy_d = 1'b1;
          if (count_i != '0) begin
            state_d    = S_SCAN;
            mem_rd_d   = 1'b1;
            mem_addr_d = base_addr_i;
            remain_d   = count_i;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_SCAN: begin
        if (remain_q == CW'(1)) begin
          mem_rd_d = 1'b0;
          remain_d = '0;
          state_d  = S_DRAIN;
        end else begin
          mem_addr_d = mem_addr_q + AW'(1);
          remain_d   = remain_q - CW'(1);
        end
      end
      S_DRAIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      remain_q   <= remain_d;
      inflight_q <= mem_rd_q;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;

`ifdef SCAN_MAX_ADDR_EN
  // Address of the read whose data arrives on the next edge, aligned with inflight_q.
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] acc_addr;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= mem_addr_q;
    end
  end

  assign acc_addr = accept ? base_addr_i : rd_addr_q;

  max_accum #(
    .DW(DW),
    .AW(AW)
  ) u_accum (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (accept),
    .valid_i   (inflight_q),
    .data_i    (mem_din_i),
    .addr_i    (acc_addr),
    .max_addr_o(max_addr_o),
    .max_val_o (max_val_o)
  );
`else
  max_accum #(
    .DW(DW)
  ) u_accum (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (accept),
    .valid_i  (inflight_q),
    .data_i   (mem_din_i),
    .max_val_o(max_val_o)
  );
`endif

endmodule

// File: tb/tb_dmem_max_scanner.sv
// Directed bench for dmem_max_scanner with a one-cycle-latency dmem model.
// Address-of-maximum checks apply only when SCAN_MAX_ADDR_EN is defined.
module tb_dmem_max_scanner;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] baseAddr;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic [31:0] maxVal;
  logic [31:0] maxAddr;
  logic        memRd;
  logic [31:0] memAddr;
  logic [31:0] memDin;

  logic [31:0] mem [0:65535];
  logic [31:0] rdAddrs [$];
  int          errors = 0;
  int          checks = 0;

  dmem_max_scanner dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .base_addr_i(baseAddr),
    .count_i    (count),
    .busy_o     (busy),
    .done_o     (done),
    .max_val_o  (maxVal),
`ifdef SCAN_MAX_ADDR_EN
    .max_addr_o (maxAddr),
`endif
    .mem_rd_o   (memRd),
    .mem_addr_o (memAddr),
    .mem_din_i  (memDin)
  );

`ifndef SCAN_MAX_ADDR_EN
  assign maxAddr = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: indexes addr[15:0], data registered on the edge that samples the read
  always @(posedge clk) begin
    if (memRd) begin
      memDin <= mem[memAddr[15:0]];
      rdAddrs.push_back(memAddr);
    end
  end

  // Starts a scan in the current cycle and returns at the negedge of the done cycle (or on timeout).
  task automatic runScan(input logic [31:0] base, input logic [15:0] cnt,
                         output int doneCyc, output int rdCnt, output int firstRd);
    int c;
    rdAddrs.delete();
    start = 1'b1;
    baseAddr = base;
    count = cnt;
    @(negedge clk);
    start = 1'b0;
    doneCyc = -1;
    rdCnt = 0;
    firstRd = -1;
    c = 1;
    while (c <= 100) begin
      if (memRd === 1'b1) begin
        rdCnt++;
        if (firstRd < 0) firstRd = c;
      end
      if (done === 1'b1) begin
        doneCyc = c;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL reset_memRd got=%0h exp=0", memRd); end
    checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL reset_memAddr got=%0h exp=0", memAddr); end
    checks++; if (maxVal !== 32'h0) begin errors++; $display("FAIL reset_maxVal got=%0h exp=0", maxVal); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int dc, rc, fr;
    mem[16'h10] = 32'd5; mem[16'h11] = 32'd9; mem[16'h12] = 32'd3; mem[16'h13] = 32'd7;
    @(negedge clk);
    runScan(32'h10, 16'd4, dc, rc, fr);
    checks++; if (dc !== 6) begin errors++; $display("FAIL basic_doneCycle got=%0d exp=6", dc); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL basic_rdCycles got=%0d exp=4", rc); end
    checks++; if (fr !== 1) begin errors++; $display("FAIL basic_firstRd got=%0d exp=1", fr); end
    checks++; if (rdAddrs.size() !== 4) begin errors++; $display("FAIL basic_nReads got=%0d exp=4", rdAddrs.size()); end
    if (rdAddrs.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rdAddrs[i] !== 32'h10 + i) begin
          errors++; $display("FAIL basic_addr%0d got=%0h exp=%0h", i, rdAddrs[i], 32'h10 + i);
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busyAtDone got=%0h exp=0", busy); end
    checks++; if (maxVal !== 32'd9) begin errors++; $display("FAIL basic_maxVal got=%0h exp=9", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h11) begin errors++; $display("FAIL basic_maxAddr got=%0h exp=11", maxAddr); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_donePulse got=%0h exp=0", done); end
    checks++; if (maxVal !== 32'd9) begin errors++; $display("FAIL basic_maxHeld got=%0h exp=9", maxVal); end
  endtask

  task automatic test_zero_count();
    int dc, rc, fr;
    @(negedge clk);
    runScan(32'h40, 16'd0, dc, rc, fr);
    checks++; if (dc !== 2) begin errors++; $display("FAIL zero_doneCycle got=%0d exp=2", dc); end
    checks++; if (rc !== 0) begin errors++; $display("FAIL zero_rdCycles got=%0d exp=0", rc); end
    checks++; if (maxVal !== 32'h0) begin errors++; $display("FAIL zero_maxVal got=%0h exp=0", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h40) begin errors++; $display("FAIL zero_maxAddr got=%0h exp=40", maxAddr); end
`endif
  endtask

  task automatic test_tie_unsigned();
    int dc, rc, fr;
    mem[16'h20] = 32'd8; mem[16'h21] = 32'd8; mem[16'h22] = 32'd2;
    @(negedge clk);
    runScan(32'h20, 16'd3, dc, rc, fr);
    checks++; if (dc !== 5) begin errors++; $display("FAIL tie_doneCycle got=%0d exp=5", dc); end
    checks++; if (maxVal !== 32'd8) begin errors++; $display("FAIL tie_maxVal got=%0h exp=8", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h20) begin errors++; $display("FAIL tie_maxAddr got=%0h exp=20", maxAddr); end
`endif
    mem[16'h30] = 32'h7FFFFFFF; mem[16'h31] = 32'hFFFFFFFF; mem[16'h32] = 32'd1;
    @(negedge clk);
    runScan(32'h30, 16'd3, dc, rc, fr);
    checks++; if (maxVal !== 32'hFFFFFFFF) begin errors++; $display("FAIL unsigned_maxVal got=%0h exp=ffffffff", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h31) begin errors++; $display("FAIL unsigned_maxAddr got=%0h exp=31", maxAddr); end
`endif
  endtask

  task automatic test_wrap();
    int dc, rc, fr;
    mem[16'hFFFE] = 32'd1; mem[16'hFFFF] = 32'd2; mem[16'h0000] = 32'hA; mem[16'h0001] = 32'd3;
    @(negedge clk);
    runScan(32'h0000FFFE, 16'd4, dc, rc, fr);
    checks++; if (dc !== 6) begin errors++; $display("FAIL wrap16_doneCycle got=%0d exp=6", dc); end
    checks++; if (rdAddrs.size() !== 4) begin errors++; $display("FAIL wrap16_nReads got=%0d exp=4", rdAddrs.size()); end
    if (rdAddrs.size() == 4) begin
      checks++; if (rdAddrs[0][15:0] !== 16'hFFFE) begin errors++; $display("FAIL wrap16_addr0 got=%0h exp=fffe", rdAddrs[0][15:0]); end
      checks++; if (rdAddrs[1][15:0] !== 16'hFFFF) begin errors++; $display("FAIL wrap16_addr1 got=%0h exp=ffff", rdAddrs[1][15:0]); end
      checks++; if (rdAddrs[2][15:0] !== 16'h0000) begin errors++; $display("FAIL wrap16_addr2 got=%0h exp=0", rdAddrs[2][15:0]); end
      checks++; if (rdAddrs[3][15:0] !== 16'h0001) begin errors++; $display("FAIL wrap16_addr3 got=%0h exp=1", rdAddrs[3][15:0]); end
    end
    checks++; if (maxVal !== 32'hA) begin errors++; $display("FAIL wrap16_maxVal got=%0h exp=a", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h00010000) begin errors++; $display("FAIL wrap16_maxAddr got=%0h exp=10000", maxAddr); end
`endif
    @(negedge clk);
    runScan(32'hFFFFFFFF, 16'd2, dc, rc, fr);
    checks++; if (rdAddrs.size() !== 2) begin errors++; $display("FAIL wrap32_nReads got=%0d exp=2", rdAddrs.size()); end
    if (rdAddrs.size() == 2) begin
      checks++; if (rdAddrs[1] !== 32'h0) begin errors++; $display("FAIL wrap32_addr1 got=%0h exp=0", rdAddrs[1]); end
    end
    checks++; if (maxVal !== 32'hA) begin errors++; $display("FAIL wrap32_maxVal got=%0h exp=a", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h0) begin errors++; $display("FAIL wrap32_maxAddr got=%0h exp=0", maxAddr); end
`endif
  endtask

  task automatic test_back_to_back();
    int dc, rc, fr;
    @(negedge clk);
    runScan(32'h20, 16'd3, dc, rc, fr);
    checks++; if (maxVal !== 32'd8) begin errors++; $display("FAIL b2b_first_maxVal got=%0h exp=8", maxVal); end
    runScan(32'h10, 16'd4, dc, rc, fr);
    checks++; if (dc !== 6) begin errors++; $display("FAIL b2b_second_doneCycle got=%0d exp=6", dc); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL b2b_second_rdCycles got=%0d exp=4", rc); end
    checks++; if (maxVal !== 32'd9) begin errors++; $display("FAIL b2b_second_maxVal got=%0h exp=9", maxVal); end
  endtask

  task automatic test_start_while_busy();
    int c;
    @(negedge clk);
    start = 1'b1; baseAddr = 32'h10; count = 16'd4;
    @(negedge clk);
    start = 1'b0; c = 1;
    @(negedge clk);
    c = 2;
    start = 1'b1; baseAddr = 32'h20; count = 16'd3;
    @(negedge clk);
    start = 1'b0; c = 3;
    while (done !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    checks++; if (c !== 6) begin errors++; $display("FAIL busyStart_doneCycle got=%0d exp=6", c); end
    checks++; if (maxVal !== 32'd9) begin errors++; $display("FAIL busyStart_maxVal got=%0h exp=9", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h11) begin errors++; $display("FAIL busyStart_maxAddr got=%0h exp=11", maxAddr); end
`endif
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busyStart_noQueueBusy got=%0h exp=0", busy); end
    checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL busyStart_noQueueRd got=%0h exp=0", memRd); end
  endtask

  task automatic test_reset_mid_scan();
    bit sawDone;
    @(negedge clk);
    start = 1'b1; baseAddr = 32'h10; count = 16'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (memRd !== 1'b1) begin errors++; $display("FAIL midReset_rdBefore got=%0h exp=1", memRd); end
    reset = 1'b1;
    #1;
    checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL midReset_rdAsync got=%0h exp=0", memRd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midReset_busy got=%0h exp=0", busy); end
    checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL midReset_memAddr got=%0h exp=0", memAddr); end
    checks++; if (maxVal !== 32'h0) begin errors++; $display("FAIL midReset_maxVal got=%0h exp=0", maxVal); end
`ifdef SCAN_MAX_ADDR_EN
    checks++; if (maxAddr !== 32'h0) begin errors++; $display("FAIL midReset_maxAddr got=%0h exp=0", maxAddr); end
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("FAIL midReset_noDone got=%0h exp=0", sawDone); end
    checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL midReset_rdAfter got=%0h exp=0", memRd); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    reset = 1'b1;
    start = 1'b0;
    baseAddr = 32'h0;
    count = 16'h0;
    memDin = 32'h0;
    test_reset();
    test_basic();
    test_zero_count();
    test_tie_unsigned();
    test_wrap();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
